// File: rtl/matrix_operand_loader.sv
// Byte-stream front end for matrix_mult. It synchronises the pin strobe, parses frames of the form
// header / mat1 / mat2, and presents the two operands with a valid/ready handshake.
module matrix_operand_loader #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       din,
  input  logic             din_strobe,
  input  logic             op_ready,
  output logic [7:0]       mat1_out,
  output logic [3:0]       mat2_out,
  output logic             op_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGetA, StGetB, StPresent} state_e;

  state_e        r_state;
  logic          r_sync1, r_sync2, r_sync3;
  logic          r_take;
  logic [7:0]    r_a;
  logic [TW-1:0] r_tcnt;

  // Registering the edge detect puts byte_take 3 clk after the pin edge, inside din's window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_take  <= 1'b0;
    end else begin
      r_sync1 <= din_strobe;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_take  <= r_sync2 & ~r_sync3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_tcnt      <= '0;
      mat1_out    <= '0;
      mat2_out    <= '0;
      op_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_tcnt <= '0;
          if (r_take && din == HEADER) begin
            r_state   <= StGetA;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
          end
        end
        StGetA: begin
          if (r_take) begin
            r_a     <= din;
            r_tcnt  <= '0;
            r_state <= StGetB;
          end else if (r_tcnt == TMAX) begin
            frame_err <= 1'b1;
            r_tcnt    <= '0;
            r_state   <= StIdle;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        StGetB: begin
          r_tcnt <= '0;
          if (r_take) begin
            if (din[7:4] == 4'h0) begin
              mat1_out <= r_a;
              mat2_out <= din[3:0];
              op_valid <= 1'b1;
              r_state  <= StPresent;
            end else begin
              frame_err <= 1'b1;
              r_state   <= StIdle;
            end
          end else if (r_tcnt == TMAX) begin
            frame_err <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        StPresent: begin
          r_tcnt <= '0;
          if (r_take) overrun <= 1'b1;
          if (op_ready) begin
            op_valid    <= 1'b0;
            frame_count <= frame_count + CNT_W'(1);
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy = (r_state != StIdle);

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: framing, handshake, errors, timeout, wrap and reset.
module tb_matrix_operand_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_strobe = 1'b0;
  logic       op_ready = 1'b0;
  logic [7:0] mat1_out;
  logic [3:0] mat2_out;
  logic       op_valid, busy, frame_err, overrun;
  logic [3:0] frame_count;

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;

  matrix_operand_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_strobe (din_strobe),
    .op_ready   (op_ready),
    .mat1_out   (mat1_out),
    .mat2_out   (mat2_out),
    .op_valid   (op_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (op_valid === 1'b1) valid_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    din = b;
    din_strobe = 1'b1;
    repeat (6) @(negedge clk);
    din_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(b);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_mat1", mat1_out, 0);
    check("rst_mat2", mat2_out, 0);
    check("rst_valid", op_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_cnt", frame_count, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame with ready already high: one-cycle valid pulse
    op_ready = 1'b1;
    valid_cycles = 0;
    send_frame(8'h3C, 8'h09);
    check("t1_pulse", valid_cycles, 1);
    check("t1_mat1", mat1_out, 8'h3C);
    check("t1_mat2", mat2_out, 4'h9);
    check("t1_cnt", frame_count, 1);
    check("t1_busy", busy, 0);
    check("t1_valid", op_valid, 0);

    // Ready held low for 20 cycles
    op_ready = 1'b0;
    send_frame(8'h7E, 8'h0C);
    check("t2_valid", op_valid, 1);
    check("t2_busy", busy, 1);
    valid_cycles = 0;
    repeat (20) @(negedge clk);
    check("t2_hold", valid_cycles, 20);
    check("t2_mat1", mat1_out, 8'h7E);
    check("t2_mat2", mat2_out, 4'hC);
    check("t2_cnt_wait", frame_count, 1);
    op_ready = 1'b1;
    @(negedge clk);
    check("t2_valid_off", op_valid, 0);
    check("t2_cnt", frame_count, 2);
    check("t2_busy", busy, 0);

    // Bad matrix-2 byte aborts; outputs untouched; next header clears error
    send_frame(8'h11, 8'hF2);
    check("t3_err", frame_err, 1);
    check("t3_busy", busy, 0);
    check("t3_mat1", mat1_out, 8'h7E);
    check("t3_mat2", mat2_out, 4'hC);
    check("t3_cnt", frame_count, 2);
    send_byte(8'hA5);
    check("t3_clear", frame_err, 0);
    check("t3_busy_a", busy, 1);

    // Timeout in GET_B
    send_byte(8'h22);
    repeat (900) @(negedge clk);
    check("t4_early", busy, 1);
    for (int i = 0; i < 200 && busy === 1'b1; i++) @(negedge clk);
    check("t4_idle", busy, 0);
    check("t4_err", frame_err, 1);
    check("t4_mat1", mat1_out, 8'h7E);

    // Stray bytes in IDLE
    send_byte(8'h00);
    send_byte(8'hFF);
    check("t5_busy", busy, 0);
    check("t5_ovr", overrun, 0);
    check("t5_err", frame_err, 1);
    check("t5_valid", op_valid, 0);

    // Overrun during PRESENT
    op_ready = 1'b0;
    send_frame(8'h44, 8'h03);
    send_byte(8'h55);
    check("t6_ovr", overrun, 1);
    check("t6_valid", op_valid, 1);
    check("t6_busy", busy, 1);
    check("t6_err", frame_err, 0);
    check("t6_mat1", mat1_out, 8'h44);
    check("t6_mat2", mat2_out, 4'h3);
    op_ready = 1'b1;
    @(negedge clk);
    check("t6_done", op_valid, 0);
    check("t6_cnt", frame_count, 3);

    // Count wrap: 13 more frames take 3 -> 0
    for (int i = 0; i < 13; i++) send_frame(8'(i + 8'h80), 8'(i));
    check("t7_wrap", frame_count, 0);
    check("t7_mat1", mat1_out, 8'h8C);
    check("t7_mat2", mat2_out, 4'hC);
    send_frame(8'h01, 8'h02);
    check("t7_after", frame_count, 1);

    // Asynchronous reset mid GET_B
    op_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h99);
    check("t8_pre_busy", busy, 1);
    #3 reset_n = 1'b0;
    #1;
    check("t8_mat1", mat1_out, 0);
    check("t8_mat2", mat2_out, 0);
    check("t8_busy", busy, 0);
    check("t8_cnt", frame_count, 0);
    check("t8_valid", op_valid, 0);
    check("t8_ovr", overrun, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    op_ready = 1'b1;
    send_frame(8'h12, 8'h05);
    check("t8_mat1_new", mat1_out, 8'h12);
    check("t8_mat2_new", mat2_out, 4'h5);
    check("t8_cnt_new", frame_count, 1);
    check("t8_busy_new", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
